// File: rtl/lcd_char_fifo.sv
// lcd_char_fifo: byte queue that replays CPU characters into Module_LCD_Control one handshake at a time.
// Optional LCD_FIFO_FLUSH_EN adds a synchronous iFlush input that empties the queue.
module lcd_char_fifo #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int ACCEPT_TIMEOUT = 255
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iData_Ready,
`ifdef LCD_FIFO_FLUSH_EN
  input  logic       iFlush,
`endif
  output logic       oReadyForData,
  output logic       oEmpty,
  output logic       oOverflow,
  output logic [7:0] oLCD_Data,
  output logic       oLCD_Data_Ready,
  input  logic       iLCD_Ready
);
  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, rp_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        dat_d;
  logic              stb_d, ovf_d, flush, full, pop, push;
`ifdef LCD_FIFO_FLUSH_EN
  assign flush = iFlush;
`else
  assign flush = 1'b0;
`endif
  assign full          = cnt_q == (ADDR_W+1)'(DEPTH);
  assign oEmpty        = cnt_q == '0;
  assign oReadyForData = !full;
  assign pop           = state_q == IDLE && !oEmpty && iLCD_Ready && !flush;
  // a pop frees a slot in the same cycle, so a push into a full queue still lands
  assign push          = iData_Ready && (!full || pop) && !flush;
  assign cnt_d         = flush ? '0 : cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  assign ovf_d         = !flush && (oOverflow || (iData_Ready && full && !pop));
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    stb_d   = 1'b0;
    dat_d   = oLCD_Data;
    if (pop) begin
      state_d = WAIT_BUSY;
      stb_d   = 1'b1;
      dat_d   = mem_q[rp_q];
    end else if (state_q == WAIT_BUSY) begin
      // controller never went busy: re-strobe the same byte and restart the wait
      if (!iLCD_Ready) state_d = WAIT_DONE;
      else if (tmo_q == TW'(ACCEPT_TIMEOUT)) stb_d = 1'b1;
      else tmo_d = tmo_q + 1'b1;
    end else if (state_q == WAIT_DONE && iLCD_Ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q         <= IDLE;
      wp_q            <= '0;
      rp_q            <= '0;
      cnt_q           <= '0;
      tmo_q           <= '0;
      oLCD_Data       <= 8'h00;
      oLCD_Data_Ready <= 1'b0;
      oOverflow       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wp_q            <= flush ? '0 : wp_q + ADDR_W'(push);
      rp_q            <= flush ? '0 : rp_q + ADDR_W'(pop);
      cnt_q           <= cnt_d;
      tmo_q           <= tmo_d;
      oLCD_Data       <= dat_d;
      oLCD_Data_Ready <= stb_d;
      oOverflow       <= ovf_d;
    end
  end
  always_ff @(posedge Clock) begin
    if (push) mem_q[wp_q] <= iData;
  end
endmodule

// File: tb/tb_lcd_char_fifo.sv
// tb_lcd_char_fifo: vector table, hand-written corner sequences and a randomized run against a queue model.
module tb_lcd_char_fifo;
  localparam int DEPTH = 16;
  logic       Clock = 1'b0, Reset = 1'b0, iData_Ready = 1'b0, iLCD_Ready = 1'b0;
  logic [7:0] iData = 8'h00;
`ifdef LCD_FIFO_FLUSH_EN
  logic       iFlush = 1'b0;
`endif
  logic       oReadyForData, oEmpty, oOverflow, oLCD_Data_Ready;
  logic [7:0] oLCD_Data;
  int         checks = 0, errors = 0;
  typedef struct {
    logic push; logic [7:0] d; logic rdy;
    logic emp; logic rfd; logic ovf; logic stb; logic [7:0] dat;
  } vec_t;
  vec_t       tv [10];
  logic [7:0] q [$];
  logic       ovf_m, p, full_b, popped;
  logic [7:0] d;
  int         lcd_st, st_was, dly, n, stbs;

  always #10 Clock = ~Clock;

  lcd_char_fifo dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iData_Ready(iData_Ready),
`ifdef LCD_FIFO_FLUSH_EN
    .iFlush(iFlush),
`endif
    .oReadyForData(oReadyForData), .oEmpty(oEmpty), .oOverflow(oOverflow),
    .oLCD_Data(oLCD_Data), .oLCD_Data_Ready(oLCD_Data_Ready), .iLCD_Ready(iLCD_Ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic push, input logic [7:0] din, input logic rdy);
    iData_Ready = push;
    iData = din;
    iLCD_Ready = rdy;
    @(posedge Clock);
    #1;
    iData_Ready = 1'b0;
  endtask

  task automatic do_reset();
    iData_Ready = 1'b0;
    iLCD_Ready = 1'b0;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input string name);
    int k = 0;
    iLCD_Ready = 1'b1;
    while (!oLCD_Data_Ready && k < 20) begin
      @(posedge Clock);
      #1;
      k++;
    end
    chk({name, "_strobe"}, oLCD_Data_Ready, 1);
    chk({name, "_data"}, oLCD_Data, b);
    iLCD_Ready = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 8'h48, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h48};
    tv[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h48};
    tv[3] = '{1'b1, 8'h49, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48};
    tv[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48};
    tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48};
    tv[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h49};
    tv[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h49};
    tv[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h49};
    tv[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h49};

    do_reset();
    chk("rst_empty", oEmpty, 1);
    chk("rst_rfd", oReadyForData, 1);
    chk("rst_ovf", oOverflow, 0);
    chk("rst_stb", oLCD_Data_Ready, 0);
    chk("rst_data", oLCD_Data, 8'h00);

    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].push, tv[i].d, tv[i].rdy);
      chk($sformatf("vec%0d_empty", i), oEmpty, tv[i].emp);
      chk($sformatf("vec%0d_rfd", i), oReadyForData, tv[i].rfd);
      chk($sformatf("vec%0d_ovf", i), oOverflow, tv[i].ovf);
      chk($sformatf("vec%0d_stb", i), oLCD_Data_Ready, tv[i].stb);
      chk($sformatf("vec%0d_data", i), oLCD_Data, tv[i].dat);
    end

    // LCD busy for 40 cycles holds back the next strobe
    cyc(1'b1, 8'h4A, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("busy_first_stb", oLCD_Data_Ready, 1);
    chk("busy_first_data", oLCD_Data, 8'h4A);
    cyc(1'b1, 8'h4B, 1'b0);
    stbs = 0;
    for (int i = 0; i < 39; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      stbs += int'(oLCD_Data_Ready);
    end
    chk("busy_no_stb", stbs, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("busy_release_stb0", oLCD_Data_Ready, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("busy_release_stb", oLCD_Data_Ready, 1);
    chk("busy_release_data", oLCD_Data, 8'h4B);

    // fill, push while full with a pop, then overflow, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == DEPTH - 2) chk("fill_rfd15", oReadyForData, 1);
    end
    chk("fill_rfd16", oReadyForData, 0);
    cyc(1'b1, 8'h55, 1'b1);
    chk("fullpop_stb", oLCD_Data_Ready, 1);
    chk("fullpop_data", oLCD_Data, 8'h00);
    chk("fullpop_ovf", oOverflow, 0);
    chk("fullpop_rfd", oReadyForData, 0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_set", oOverflow, 1);
    chk("ovf_rfd", oReadyForData, 0);
    for (int i = 1; i < DEPTH; i++) expect_byte(8'(i), $sformatf("drain%0d", i));
    expect_byte(8'h55, "drain_55");
    stbs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      stbs += int'(oLCD_Data_Ready);
    end
    chk("no_aa_stb", stbs, 0);
    chk("drained_empty", oEmpty, 1);
    chk("ovf_sticky", oOverflow, 1);

    // controller never drops ready: strobe repeats with the same byte
    cyc(1'b1, 8'h77, 1'b1);
    cyc(1'b1, 8'h78, 1'b1);
    chk("tmo_first_stb", oLCD_Data_Ready, 1);
    chk("tmo_first_data", oLCD_Data, 8'h77);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        cyc(1'b0, 8'h00, 1'b1);
        n++;
      end while (!oLCD_Data_Ready && n < 600);
      chk($sformatf("tmo_gap%0d", r), n, 256);
      chk($sformatf("tmo_data%0d", r), oLCD_Data, 8'h77);
      chk($sformatf("tmo_not_popped%0d", r), oEmpty, 0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    expect_byte(8'h78, "tmo_next");

    // asynchronous reset while a strobe is out and 5 bytes are queued
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid_stb", oLCD_Data_Ready, 1);
    chk("mid_queued", oEmpty, 0);
    #3 Reset = 1'b0;
    #1;
    chk("arst_stb", oLCD_Data_Ready, 0);
    chk("arst_empty", oEmpty, 1);
    chk("arst_data", oLCD_Data, 8'h00);
    chk("arst_rfd", oReadyForData, 1);
    #5 Reset = 1'b1;
    @(posedge Clock);
    #1;

    // randomized traffic against a queue model with a randomly slow LCD
    do_reset();
    q.delete();
    ovf_m = 1'b0;
    lcd_st = 0;
    dly = 0;
    for (int c = 0; c < 4000; c++) begin
      p = (c < 3400) && ($urandom_range(0, 99) < (((c / 500) % 2) != 0 ? 45 : 8));
      d = 8'($urandom);
      st_was = lcd_st;
      full_b = q.size() == DEPTH;
      cyc(p, d, lcd_st != 2);
      popped = oLCD_Data_Ready;
      if (popped) begin
        chk("rnd_strobe_when_ready", st_was == 0, 1);
        chk("rnd_pop_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("rnd_data", oLCD_Data, q.pop_front());
      end
      if (p) begin
        if (!full_b || popped) q.push_back(d);
        else ovf_m = 1'b1;
      end
      chk("rnd_empty", oEmpty, q.size() == 0);
      chk("rnd_rfd", oReadyForData, q.size() < DEPTH);
      chk("rnd_ovf", oOverflow, ovf_m);
      if (lcd_st == 0) begin
        if (popped) begin
          lcd_st = 1;
          dly = $urandom_range(0, 3);
        end
      end else if (lcd_st == 1) begin
        if (dly == 0) begin
          lcd_st = 2;
          dly = $urandom_range(1, 6);
        end else dly--;
      end else begin
        dly--;
        if (dly == 0) lcd_st = 0;
      end
    end
    chk("rnd_drained_model", q.size(), 0);
    chk("rnd_drained_dut", oEmpty, 1);

`ifdef LCD_FIFO_FLUSH_EN
    do_reset();
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
    chk("fl_ovf_pre", oOverflow, 1);
    iFlush = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0);
    iFlush = 1'b0;
    chk("fl_empty", oEmpty, 1);
    chk("fl_ovf", oOverflow, 0);
    chk("fl_rfd", oReadyForData, 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0);
    chk("fl7_queued", oEmpty, 0);
    iFlush = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    iFlush = 1'b0;
    chk("fl7_empty", oEmpty, 1);
    chk("fl7_ovf", oOverflow, 0);
    cyc(1'b1, 8'h3C, 1'b0);
    expect_byte(8'h3C, "fl_after");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
